ram_port_arbiter: RTL

- Sequences the single byte-serial RAM port and shares it between two requesters: the instruction-fetch unit (IF) and the load/store unit (LSU).
- Owns round-robin arbitration, multi-byte assembly and splitting, IO-write back-pressure, and fetch abort on pipeline flush.
- Sits between the IF/LSU stages and the top-level RAM/IO bus.

---
 rtl/ram_port_arbiter_if.sv | 34 +++
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the IF, LSU and RAM/IO-bus signals around the RAM port arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding pipeline and memory.
interface ram_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [2:0]  lsu_len;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        io_buffer_full;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [1:0]  busy;

   modport slave (
      input  if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_len,
             io_buffer_full, mem_din,
      output if_done, if_data, lsu_done, lsu_rdata, mem_dout, mem_a, mem_wr, busy
   );

   modport master (
      output if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_len,
             io_buffer_full, mem_din,
      input  if_done, if_data, lsu_done, lsu_rdata, mem_dout, mem_a, mem_wr, busy
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the byte-serial RAM port between instruction fetch and the LSU:
// round-robin grant, byte assembly/splitting, IO write back-pressure and
// fetch abort on flush.
module ram_port_arbiter #(
   parameter int unsigned IO_ADDR_BIT = 17
) (
   input logic               clk_in,
   input logic               rst_in,
   input logic               rdy_in,
   input logic               flush_in,
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e      state_q;
   logic        own_if_q;   // current transaction belongs to IF
   logic        last_if_q;  // last grant went to IF
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;
   logic [31:0] if_data_q;
   logic [31:0] lsu_rdata_q;
   logic [2:0]  len_q;
   logic [2:0]  cnt_q;

   logic        req_if;
   logic        gnt_any;
   logic        gnt_if;
   logic [2:0]  lsu_len_dec;
   logic [31:0] byte_addr;
   logic [31:0] wr_shift;
   logic        io_stall;
   logic        if_done;
   logic        lsu_done;
   logic        active;

   assign req_if    = bus.if_req & ~flush_in;
   assign gnt_any   = req_if | bus.lsu_req;
   assign gnt_if    = req_if & (~bus.lsu_req | ~last_if_q);
   assign byte_addr = addr_q + 32'(cnt_q);
   assign wr_shift  = wdata_q >> {cnt_q[1:0], 3'b000};
   assign io_stall  = (state_q == StWrite) && (byte_addr[IO_ADDR_BIT -: 2] == 2'b11)
                      && bus.io_buffer_full;

   // Decode the LSU byte count; anything but 1 or 2 means a full word.
   always_comb begin
      lsu_len_dec = 3'd4;
      case (bus.lsu_len)
         3'd1:    lsu_len_dec = 3'd1;
         3'd2:    lsu_len_dec = 3'd2;
         default: lsu_len_dec = 3'd4;
      endcase
   end

   // RAM bus drive decoded from state. While frozen in READ, re-issue the
   // address whose byte is captured next so mem_din is right on resume.
   always_comb begin
      bus.mem_a    = '0;
      bus.mem_wr   = 1'b0;
      bus.mem_dout = '0;
      if (state_q == StWrite) begin
         bus.mem_a    = byte_addr;
         bus.mem_dout = wr_shift[7:0];
         bus.mem_wr   = rdy_in & ~io_stall;
      end else if (state_q == StRead) begin
         if (!rdy_in) begin
            bus.mem_a = (cnt_q == 3'd0) ? addr_q : byte_addr - 32'd1;
         end else if (cnt_q < len_q) begin
            bus.mem_a = byte_addr;
         end
      end
   end

   // Done pulses last one active cycle; a flush in the done cycle drops the fetch.
   assign if_done       = (state_q == StDone) & own_if_q & rdy_in & ~flush_in;
   assign lsu_done      = (state_q == StDone) & ~own_if_q & rdy_in;
   assign active        = (state_q == StRead) || (state_q == StWrite);
   assign bus.if_done   = if_done;
   assign bus.lsu_done  = lsu_done;
   assign bus.if_data   = if_done ? buf_q : if_data_q;
   assign bus.lsu_rdata = (lsu_done & ~we_q) ? buf_q : lsu_rdata_q;
   assign bus.busy      = {active & own_if_q, active & ~own_if_q};

   // Transaction sequencer: grant, byte loop, done, with freeze on !rdy_in.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         own_if_q    <= 1'b0;
         last_if_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         buf_q       <= '0;
         if_data_q   <= '0;
         lsu_rdata_q <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
      end else if (rdy_in) begin
         case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  own_if_q  <= gnt_if;
                  last_if_q <= gnt_if;
                  addr_q    <= gnt_if ? bus.if_addr : bus.lsu_addr;
                  len_q     <= gnt_if ? 3'd4 : lsu_len_dec;
                  wdata_q   <= bus.lsu_wdata;
                  we_q      <= ~gnt_if & bus.lsu_we;
                  cnt_q     <= '0;
                  buf_q     <= '0;
                  state_q   <= (~gnt_if & bus.lsu_we) ? StWrite : StRead;
               end
            end
            StRead: begin
               if (own_if_q && flush_in) begin
                  state_q <= StIdle;
               end else begin
                  for (int i = 0; i < 4; i++) begin
                     if (cnt_q == 3'(i + 1)) buf_q[8*i +: 8] <= bus.mem_din;
                  end
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == len_q) state_q <= StDone;
               end
            end
            StWrite: begin
               if (!io_stall) begin
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == len_q - 3'd1) state_q <= StDone;
               end
            end
            StDone: begin
               if (if_done) if_data_q <= buf_q;
               if (lsu_done && !we_q) lsu_rdata_q <= buf_q;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
